topk_stream_select: RTL and testbench
=====================================

Name: topk_stream_select

Overview:
- Parametrised streaming top-K selector. It is the next generation of the fixed top-10 selection sorter used by the PageRank sort stage.
- Accepts one score per cycle over a valid/ready handshake and tags each score with its arrival index as its ID.
- Maintains a sorted K-entry register list by parallel compare-and-shift insertion.
- Presents the final ranked scores and IDs under an output valid/ready handshake. The rank stage then reads the top-K page IDs.

Parameters:
- DATA_WIDTH, 16, score width in bits (unsigned).
- NUM_WORDS, 32, maximum scores per frame.
- K, 10, list depth; 1 <= K <= NUM_WORDS.
- ID_WIDTH, 6, ID width; must satisfy 2^ID_WIDTH >= NUM_WORDS.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, score present.
- in_ready, output, 1, block can accept a score.
- in_data, input, DATA_WIDTH, unsigned score.
- in_last, input, 1, final score of the frame.
- out_valid, output, 1, result list valid.
- out_ready, input, 1, consumer takes the result.
- array_out, output, DATA_WIDTH*K, ranked scores; rank 0 (best) in bits [DATA_WIDTH-1:0].
- id_out, output, ID_WIDTH*K, IDs in the same rank order.
- count_out, output, ID_WIDTH+1, number of valid ranks, min(words accepted, K).

Behaviour:
- Reset (async, rst=1):
  - state=ACCEPT, in_ready=1, out_valid=0.
  - All list scores 0, all IDs 0, count_out=0, index counter 0.
  - Reset mid-frame discards the partial frame.
- States:
  - ACCEPT: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept event: in_valid && in_ready on a rising clk edge.
  - The new entry has score=in_data and ID=index counter. Then index increments and count_out increments, saturating at K.
- Insertion, performed in the accept cycle:
  - Position p = number of occupied ranks r with score[r] >= in_data.
  - If p < K: ranks p..K-2 shift down one place, rank K-1 is dropped, and the new entry is written at rank p.
  - If p == K: the list is unchanged.
  - Ties: an earlier arrival stays ahead of a later one (stable, lower ID ranks first among equal scores).
  - Unoccupied ranks never block insertion.
- Frame end:
  - An accept with in_last=1, or the accept that brings the index to NUM_WORDS, moves ACCEPT to DONE.
  - That accept's insertion is included, so out_valid is asserted on the next cycle (1-cycle latency from the last accept).
- DONE:
  - array_out, id_out and count_out are held stable while out_valid=1 and out_ready=0.
  - out_ready=1 moves DONE to ACCEPT on that edge. That edge also clears the list to 0, count_out to 0 and the index to 0.
  - in_ready returns to 1 on the following cycle. No words are accepted during DONE.
- Outputs:
  - array_out, id_out and count_out are registered and visible during ACCEPT as the running partial result.
  - Consumers must qualify them with out_valid.
- Width rules:
  - Comparisons are unsigned over DATA_WIDTH.
  - The index counter is ID_WIDTH+1 bits internally; IDs are its low ID_WIDTH bits.
- in_valid=0 in ACCEPT: hold all state.
- in_last with in_valid=0 is ignored.

Optional Feature:
- Macro TOPK_BOTTOM_EN.
- When defined, the block selects the K smallest scores:
  - Rank 0 is the minimum.
  - Position p counts occupied ranks with score[r] <= in_data.
  - Tie rule, handshakes, timing and reset are unchanged.
- When not defined, the block selects the K largest scores as described above.

Test Plan:
- Descending sequence with defaults (32 words, in_data = 31 - i, last on word 31):
  - out_valid 1 cycle after the last accept.
  - array_out = 31..22, id_out = 0..9, count_out = 10.
- Ascending 0..31 with 2 idle cycles inserted mid-stream:
  - array_out = 31..22, id_out = 31..22.
  - The idle cycles do not change the list.
- Ties (scores 5,7,7,5,7 with last, K=3):
  - array_out = 7,7,7, id_out = 1,2,4, count_out = 3.
- Short frame (3 words 9,4,12 with last):
  - array_out ranks 0..2 = 12,9,4, ids 2,0,1, count_out = 3.
  - Ranks 3..9 = 0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: outputs stable and in_ready=0. Then pulse out_ready: in_ready returns to 1 the following cycle.
  - In a separate frame, assert rst after 10 words: list and count clear immediately and out_valid stays 0.
- With TOPK_BOTTOM_EN, stream 10,3,8,3,1 with last, K=2:
  - array_out = 1,3, id_out = 4,1.

Source files
------------

// File: rtl/topk_stream_select.sv
// Streaming top-K selector: accepts one unsigned score per cycle, tags it with
// its arrival index and keeps a sorted K-entry list by parallel compare-and-shift
// insertion. The finished list is offered under a valid/ready handshake.
// Optional macro TOPK_BOTTOM_EN selects the K smallest scores instead of the
// K largest.
`timescale 1ns/1ps

module topk_stream_select #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_WORDS  = 32,
  parameter int unsigned K          = 10,
  parameter int unsigned ID_WIDTH   = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*K-1:0]    array_out,
  output logic [ID_WIDTH*K-1:0]      id_out,
  output logic [ID_WIDTH:0]          count_out
);

  localparam int unsigned CW = ID_WIDTH + 1;
  localparam logic [CW-1:0] KCnt        = CW'(K);
  localparam logic [CW-1:0] NumWordsCnt = CW'(NUM_WORDS);

  typedef enum logic [0:0] {StAccept, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] score_q [K];
  logic [DATA_WIDTH-1:0] score_d [K];
  logic [ID_WIDTH-1:0]   id_q    [K];
  logic [ID_WIDTH-1:0]   id_d    [K];
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         idx_q, idx_d;

  logic                  accept;
  logic                  frame_end;
  logic [K-1:0]          keep;
  logic [CW-1:0]         idx_inc;

  assign accept    = in_valid && in_ready;
  assign idx_inc   = idx_q + 1'b1;
  assign frame_end = in_last || (idx_inc == NumWordsCnt);

  // Per-rank "stays ahead of the new word": occupied and better-or-equal. Equal
  // scores keep the older entry ahead, which gives the stable tie order.
  always_comb begin
    keep = '0;
    for (int r = 0; r < K; r++) begin
`ifdef TOPK_BOTTOM_EN
      keep[r] = (CW'(r) < count_q) && (score_q[r] <= in_data);
`else
      keep[r] = (CW'(r) < count_q) && (score_q[r] >= in_data);
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAccept;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the frame closes on in_last or on the NUM_WORDS-th word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccept: if (accept && frame_end) state_d = StDone;
      StDone:   if (out_ready)           state_d = StAccept;
      default:                           state_d = StAccept;
    endcase
  end

  // Output decode for the handshake signals.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StAccept: in_ready  = 1'b1;
      StDone:   out_valid = 1'b1;
      default:  in_ready  = 1'b0;
    endcase
  end

  // List update: insert on accept, clear when the result is consumed.
  always_comb begin
    score_d = score_q;
    id_d    = id_q;
    count_d = count_q;
    idx_d   = idx_q;
    if (state_q == StDone) begin
      if (out_ready) begin
        for (int r = 0; r < K; r++) begin
          score_d[r] = '0;
          id_d[r]    = '0;
        end
        count_d = '0;
        idx_d   = '0;
      end
    end else if (accept) begin
      // Ranks that keep their entry form a prefix; the first non-kept rank takes
      // the new word and everything after it shifts down, dropping rank K-1.
      if (!keep[0]) begin
        score_d[0] = in_data;
        id_d[0]    = idx_q[ID_WIDTH-1:0];
      end
      for (int r = 1; r < K; r++) begin
        if (!keep[r]) begin
          if (keep[r-1]) begin
            score_d[r] = in_data;
            id_d[r]    = idx_q[ID_WIDTH-1:0];
          end else begin
            score_d[r] = score_q[r-1];
            id_d[r]    = id_q[r-1];
          end
        end
      end
      count_d = (count_q == KCnt) ? count_q : count_q + 1'b1;
      idx_d   = idx_inc;
    end
  end

  // List, count and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        score_q[r] <= '0;
        id_q[r]    <= '0;
      end
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      for (int r = 0; r < K; r++) begin
        score_q[r] <= score_d[r];
        id_q[r]    <= id_d[r];
      end
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  // Flatten the registered list onto the output buses, rank 0 in the low bits.
  always_comb begin
    array_out = '0;
    id_out    = '0;
    for (int r = 0; r < K; r++) begin
      array_out[r*DATA_WIDTH +: DATA_WIDTH] = score_q[r];
      id_out[r*ID_WIDTH +: ID_WIDTH]        = id_q[r];
    end
    count_out = count_q;
  end

endmodule

// File: tb/tb_topk_stream_select.sv
// Scoreboard bench for topk_stream_select: stimulus pushes the expected result
// list per frame, a monitor per instance pops and compares on each handshake.
`timescale 1ns/1ps

module tb_topk_stream_select;

`ifdef TOPK_BOTTOM_EN
  localparam int KS = 2;
`else
  localparam int KS = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default K=10. Instance B: small K for ties / bottom mode.
  logic         a_valid = 1'b0, a_last = 1'b0, a_oready = 1'b0;
  logic [15:0]  a_data = '0;
  logic         a_ready, a_ovalid;
  logic [159:0] a_arr;
  logic [59:0]  a_id;
  logic [6:0]   a_cnt;

  logic              b_valid = 1'b0, b_last = 1'b0, b_oready = 1'b0;
  logic [15:0]       b_data = '0;
  logic              b_ready, b_ovalid;
  logic [16*KS-1:0]  b_arr;
  logic [6*KS-1:0]   b_id;
  logic [6:0]        b_cnt;

  topk_stream_select #(.DATA_WIDTH(16), .NUM_WORDS(32), .K(10), .ID_WIDTH(6)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .in_last(a_last), .out_valid(a_ovalid), .out_ready(a_oready), .array_out(a_arr),
    .id_out(a_id), .count_out(a_cnt)
  );

  topk_stream_select #(.DATA_WIDTH(16), .NUM_WORDS(32), .K(KS), .ID_WIDTH(6)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_last(b_last), .out_valid(b_ovalid), .out_ready(b_oready), .array_out(b_arr),
    .id_out(b_id), .count_out(b_cnt)
  );

  typedef struct packed {
    logic [159:0] arr;
    logic [59:0]  ids;
    logic [6:0]   cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   es[10];
  int   ei[10];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t build(input int n, input int cnt);
    exp_t e;
    e.arr = '0;
    e.ids = '0;
    for (int r = 0; r < n; r++) begin
      e.arr[16*r +: 16] = 16'(es[r]);
      e.ids[6*r +: 6]   = 6'(ei[r]);
    end
    e.cnt = 7'(cnt);
    return e;
  endfunction

  task automatic push(input bit which, input int n, input int cnt);
    if (which) qb.push_back(build(n, cnt));
    else       qa.push_back(build(n, cnt));
  endtask

  task automatic send(input bit which, input int d, input bit last);
    if (which) begin
      chk("b_in_ready", 160'(b_ready), 160'(1));
      b_valid = 1'b1; b_data = 16'(d); b_last = last;
    end else begin
      chk("a_in_ready", 160'(a_ready), 160'(1));
      a_valid = 1'b1; a_data = 16'(d); a_last = last;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_last = 1'b0;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  // Bounded wait until both scoreboards have drained.
  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending a=%0d b=%0d want 0", qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  // Monitors: compare on each output handshake.
  always @(negedge clk) begin
    if (a_ovalid && a_oready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_out", 160'(1), 160'(0));
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_array_out", a_arr, e.arr);
        chk("a_id_out", 160'(a_id), 160'(e.ids));
        chk("a_count_out", 160'(a_cnt), 160'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (b_ovalid && b_oready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_out", 160'(1), 160'(0));
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_array_out", 160'(b_arr), e.arr);
        chk("b_id_out", 160'(b_id), 160'(e.ids));
        chk("b_count_out", 160'(b_cnt), 160'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t cur;
    #2;
    chk("rst_in_ready", 160'(a_ready), 160'(1));
    chk("rst_out_valid", 160'(a_ovalid), 160'(0));
    chk("rst_count", 160'(a_cnt), 160'(0));
    chk("rst_array", a_arr, 160'(0));
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

`ifndef TOPK_BOTTOM_EN
    // Descending 31..0, last on word 31.
    for (int i = 0; i < 10; i++) begin es[i] = 31 - i; ei[i] = i; end
    push(0, 10, 10);
    cur = build(10, 10);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) chk("desc_ovalid_before_last", 160'(a_ovalid), 160'(0));
      send(0, 31 - i, i == 31);
    end
    idle_inputs();
    chk("desc_ovalid_latency", 160'(a_ovalid), 160'(1));
    // Backpressure: hold out_ready low for 5 cycles.
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_array_stable", a_arr, cur.arr);
      chk("bp_ids_stable", 160'(a_id), 160'(cur.ids));
      chk("bp_in_ready", 160'(a_ready), 160'(0));
    end
    a_oready = 1'b1;
    @(posedge clk);
    #1;
    a_oready = 1'b0;
    chk("bp_in_ready_back", 160'(a_ready), 160'(1));
    chk("bp_ovalid_clear", 160'(a_ovalid), 160'(0));
    chk("bp_count_clear", 160'(a_cnt), 160'(0));
    chk("bp_array_clear", a_arr, 160'(0));

    // Ascending 0..31 with two idle cycles after word 15.
    for (int i = 0; i < 16; i++) send(0, i, 1'b0);
    idle_inputs();
    for (int i = 0; i < 10; i++) begin es[i] = 15 - i; ei[i] = 15 - i; end
    cur = build(10, 10);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("asc_idle_array", a_arr, cur.arr);
      chk("asc_idle_ids", 160'(a_id), 160'(cur.ids));
    end
    for (int i = 0; i < 10; i++) begin es[i] = 31 - i; ei[i] = 31 - i; end
    push(0, 10, 10);
    for (int i = 16; i < 32; i++) send(0, i, i == 31);
    idle_inputs();
    a_oready = 1'b1;
    drain();
    a_oready = 1'b0;

    // Short frame 9,4,12.
    es[0] = 12; es[1] = 9; es[2] = 4;
    ei[0] = 2;  ei[1] = 0; ei[2] = 1;
    push(0, 3, 3);
    send(0, 9, 1'b0);
    send(0, 4, 1'b0);
    send(0, 12, 1'b1);
    idle_inputs();
    a_oready = 1'b1;
    drain();
    a_oready = 1'b0;

    // Reset mid-frame after 10 words.
    for (int i = 0; i < 10; i++) send(0, 100 + i, 1'b0);
    idle_inputs();
    chk("mid_count_before_rst", 160'(a_cnt), 160'(10));
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 160'(a_cnt), 160'(0));
    chk("mid_rst_array", a_arr, 160'(0));
    chk("mid_rst_ids", 160'(a_id), 160'(0));
    chk("mid_rst_ovalid", 160'(a_ovalid), 160'(0));
    #2 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_rst_ovalid", 160'(a_ovalid), 160'(0));
    end
    // Index must restart at 0 after reset.
    es[0] = 6; es[1] = 5; ei[0] = 1; ei[1] = 0;
    push(0, 2, 2);
    send(0, 5, 1'b0);
    send(0, 6, 1'b1);
    idle_inputs();
    a_oready = 1'b1;
    drain();
    a_oready = 1'b0;

    // Ties on K=3: 5,7,7,5,7.
    es[0] = 7; es[1] = 7; es[2] = 7;
    ei[0] = 1; ei[1] = 2; ei[2] = 4;
    push(1, 3, 3);
    send(1, 5, 1'b0);
    send(1, 7, 1'b0);
    send(1, 7, 1'b0);
    send(1, 5, 1'b0);
    send(1, 7, 1'b1);
    idle_inputs();
    b_oready = 1'b1;
    drain();
    b_oready = 1'b0;

    // 32 words without in_last: frame closes on the NUM_WORDS-th word.
    es[0] = 31; es[1] = 30; es[2] = 29;
    ei[0] = 31; ei[1] = 30; ei[2] = 29;
    push(1, 3, 3);
    for (int i = 0; i < 32; i++) send(1, i, 1'b0);
    idle_inputs();
    chk("b_full_ovalid", 160'(b_ovalid), 160'(1));
    b_oready = 1'b1;
    drain();
    b_oready = 1'b0;
`else
    // Bottom mode, K=2: 10,3,8,3,1.
    es[0] = 1; es[1] = 3; ei[0] = 4; ei[1] = 1;
    push(1, 2, 2);
    send(1, 10, 1'b0);
    send(1, 3, 1'b0);
    send(1, 8, 1'b0);
    send(1, 3, 1'b0);
    send(1, 1, 1'b1);
    idle_inputs();
    chk("bot_ovalid_latency", 160'(b_ovalid), 160'(1));
    b_oready = 1'b1;
    drain();
    b_oready = 1'b0;

    // 32 ascending words without in_last keep the two smallest.
    es[0] = 0; es[1] = 1; ei[0] = 0; ei[1] = 1;
    push(1, 2, 2);
    for (int i = 0; i < 32; i++) send(1, i, 1'b0);
    idle_inputs();
    chk("bot_full_ovalid", 160'(b_ovalid), 160'(1));
    b_oready = 1'b1;
    drain();
    b_oready = 1'b0;
`endif

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
